// File: rtl/clock_pkg.sv
// Shared types and field limits for the clock's time/alarm setting path.
// Also holds the modular step helpers used when editing HH and MM fields.
package clock_pkg;

   localparam int HH_W = 5;
   localparam int MM_W = 6;
   localparam logic [HH_W-1:0] MAX_HH = 5'd23;
   localparam logic [MM_W-1:0] MAX_MM = 6'd59;

   typedef enum logic [2:0] {
      IDLE,
      T_HH,
      T_MM,
      A_HH,
      A_MM
   } set_state_t;

   typedef enum logic [1:0] {
      FIELD_NONE = 2'd0,
      FIELD_HH   = 2'd1,
      FIELD_MM   = 2'd2
   } field_t;

   // up=1 increments, up=0 decrements, both wrapping inside 0..MAX
   function automatic logic [HH_W-1:0] hh_step(input logic [HH_W-1:0] v, input logic up);
      if (up) return (v == MAX_HH) ? '0 : v + 1'b1;
      else    return (v == '0) ? MAX_HH : v - 1'b1;
   endfunction

   function automatic logic [MM_W-1:0] mm_step(input logic [MM_W-1:0] v, input logic up);
      if (up) return (v == MAX_MM) ? '0 : v + 1'b1;
      else    return (v == '0) ? MAX_MM : v - 1'b1;
   endfunction

endpackage

// File: rtl/time_set_controller_button_conditioner.sv
// One raw push-button to a clean event pulse: 2-FF sync, debounce, rising-edge
// pulse and, when REPEAT_EN is set, periodic auto-repeat while held.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 50,
   parameter bit REPEAT_EN       = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic event_o
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RP_W = $clog2(REPEAT_CYCLES + 1);

   logic            sync1_q, sync2_q;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            level_q, level_d;
   logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic            event_q, event_d;

   always_comb begin
      db_cnt_d  = '0;
      level_d   = level_q;
      rep_cnt_d = '0;
      event_d   = 1'b0;
      // Count consecutive synced samples that disagree with the accepted level
      if (sync2_q != level_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
      if (level_d && !level_q) begin
         event_d = 1'b1;
      end else if (REPEAT_EN && level_q && level_d) begin
         if (rep_cnt_q == RP_W'(REPEAT_CYCLES - 1)) begin
            event_d = 1'b1;
         end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         rep_cnt_q <= '0;
         event_q   <= 1'b0;
      end else begin
         sync1_q   <= btn_i;
         sync2_q   <= sync1_q;
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         rep_cnt_q <= rep_cnt_d;
         event_q   <= event_d;
      end
   end

   assign event_o = event_q;

endmodule

// File: rtl/time_set_controller.sv
// Button-driven editor for the running time and the alarm: mode walks
// T_HH -> T_MM -> A_HH -> A_MM, inc/dec edit, commits go out as one-cycle strobes.
module time_set_controller
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 50,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            btn_mode,
   input  logic            btn_inc,
   input  logic            btn_dec,
   input  logic [HH_W-1:0] cur_hh,
   input  logic [MM_W-1:0] cur_mm,
   output logic [HH_W-1:0] set_hh,
   output logic [MM_W-1:0] set_mm,
   output logic            time_load,
   output logic [HH_W-1:0] alarm_hh,
   output logic [MM_W-1:0] alarm_mm,
   output logic            alarm_load,
   output logic [1:0]      edit_field,
   output logic            edit_alarm
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic mode_ev, inc_ev, dec_ev;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .REPEAT_EN      (1'b0)
   ) u_mode (.clk(clk), .rst_n(rst_n), .btn_i(btn_mode), .event_o(mode_ev));

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .REPEAT_EN      (1'b1)
   ) u_inc (.clk(clk), .rst_n(rst_n), .btn_i(btn_inc), .event_o(inc_ev));

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .REPEAT_EN      (1'b1)
   ) u_dec (.clk(clk), .rst_n(rst_n), .btn_i(btn_dec), .event_o(dec_ev));

   set_state_t      state_q, state_d;
   logic [HH_W-1:0] edit_hh_q, edit_hh_d;
   logic [MM_W-1:0] edit_mm_q, edit_mm_d;
   logic [HH_W-1:0] set_hh_q, set_hh_d;
   logic [MM_W-1:0] set_mm_q, set_mm_d;
   logic [HH_W-1:0] alarm_hh_q, alarm_hh_d;
   logic [MM_W-1:0] alarm_mm_q, alarm_mm_d;
   logic            time_load_q, time_load_d;
   logic            alarm_load_q, alarm_load_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   field_t          field;

   logic any_ev, step_en;
   // Opposing inc/dec in the same cycle cancel out
   assign any_ev  = mode_ev | inc_ev | dec_ev;
   assign step_en = inc_ev ^ dec_ev;

   always_comb begin
      state_d      = state_q;
      edit_hh_d    = edit_hh_q;
      edit_mm_d    = edit_mm_q;
      set_hh_d     = set_hh_q;
      set_mm_d     = set_mm_q;
      alarm_hh_d   = alarm_hh_q;
      alarm_mm_d   = alarm_mm_q;
      time_load_d  = 1'b0;
      alarm_load_d = 1'b0;
      to_cnt_d     = '0;

      // Idle timeout aborts without any strobe
      if (state_q != IDLE && !any_ev) begin
         if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
         end else begin
            to_cnt_d = to_cnt_q + 1'b1;
         end
      end

      if (mode_ev) begin
         case (state_q)
            IDLE: begin
               state_d   = T_HH;
               edit_hh_d = cur_hh;
               edit_mm_d = cur_mm;
            end
            T_HH: state_d = T_MM;
            T_MM: begin
               state_d     = A_HH;
               set_hh_d    = edit_hh_q;
               set_mm_d    = edit_mm_q;
               time_load_d = 1'b1;
               edit_hh_d   = alarm_hh_q;
               edit_mm_d   = alarm_mm_q;
            end
            A_HH: state_d = A_MM;
            A_MM: begin
               state_d      = IDLE;
               alarm_hh_d   = edit_hh_q;
               alarm_mm_d   = edit_mm_q;
               alarm_load_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end else if (step_en) begin
         case (state_q)
            T_HH, A_HH: edit_hh_d = hh_step(edit_hh_q, inc_ev);
            T_MM, A_MM: edit_mm_d = mm_step(edit_mm_q, inc_ev);
            default: ;
         endcase
      end
   end

   always_comb begin
      field = FIELD_NONE;
      case (state_q)
         T_HH, A_HH: field = FIELD_HH;
         T_MM, A_MM: field = FIELD_MM;
         default:    field = FIELD_NONE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         edit_hh_q    <= '0;
         edit_mm_q    <= '0;
         set_hh_q     <= '0;
         set_mm_q     <= '0;
         alarm_hh_q   <= '0;
         alarm_mm_q   <= '0;
         time_load_q  <= 1'b0;
         alarm_load_q <= 1'b0;
         to_cnt_q     <= '0;
      end else begin
         state_q      <= state_d;
         edit_hh_q    <= edit_hh_d;
         edit_mm_q    <= edit_mm_d;
         set_hh_q     <= set_hh_d;
         set_mm_q     <= set_mm_d;
         alarm_hh_q   <= alarm_hh_d;
         alarm_mm_q   <= alarm_mm_d;
         time_load_q  <= time_load_d;
         alarm_load_q <= alarm_load_d;
         to_cnt_q     <= to_cnt_d;
      end
   end

   assign set_hh     = set_hh_q;
   assign set_mm     = set_mm_q;
   assign time_load  = time_load_q;
   assign alarm_hh   = alarm_hh_q;
   assign alarm_mm   = alarm_mm_q;
   assign alarm_load = alarm_load_q;
   assign edit_field = field;
   assign edit_alarm = (state_q == A_HH) || (state_q == A_MM);

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller with short debounce/repeat/timeout
// settings; strobes are counted continuously and checked around each step.
module tb_time_set_controller;

   logic       clk;
   logic       rst_n;
   logic       btn_mode, btn_inc, btn_dec;
   logic [4:0] cur_hh;
   logic [5:0] cur_mm;
   logic [4:0] set_hh;
   logic [5:0] set_mm;
   logic       time_load;
   logic [4:0] alarm_hh;
   logic [5:0] alarm_mm;
   logic       alarm_load;
   logic [1:0] edit_field;
   logic       edit_alarm;

   int vec_cnt = 0;
   int err_cnt = 0;
   int tl_cnt  = 0;
   int al_cnt  = 0;
   int tl_ref, al_ref;

   time_set_controller #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_CYCLES  (8),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .btn_dec   (btn_dec),
      .cur_hh    (cur_hh),
      .cur_mm    (cur_mm),
      .set_hh    (set_hh),
      .set_mm    (set_mm),
      .time_load (time_load),
      .alarm_hh  (alarm_hh),
      .alarm_mm  (alarm_mm),
      .alarm_load(alarm_load),
      .edit_field(edit_field),
      .edit_alarm(edit_alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (time_load === 1'b1) tl_cnt++;
      if (alarm_load === 1'b1) al_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold the chosen raw buttons for 'hold' cycles, release, then let everything settle
   task automatic press(input logic m, input logic i, input logic d, input int hold);
      @(negedge clk);
      btn_mode = m;
      btn_inc  = i;
      btn_dec  = d;
      cyc(hold);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_dec  = 1'b0;
      cyc(14);
   endtask

   initial begin
      rst_n    = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_dec  = 1'b0;
      cur_hh   = 5'd0;
      cur_mm   = 6'd0;
      cyc(3);
      rst_n = 1'b1;

      // Reset and idle
      cyc(20);
      chk("rst_set_hh", 32'(set_hh), 32'd0);
      chk("rst_set_mm", 32'(set_mm), 32'd0);
      chk("rst_alarm_hh", 32'(alarm_hh), 32'd0);
      chk("rst_alarm_mm", 32'(alarm_mm), 32'd0);
      chk("rst_edit_field", 32'(edit_field), 32'd0);
      chk("rst_edit_alarm", 32'(edit_alarm), 32'd0);
      chk("rst_no_strobes", 32'(tl_cnt + al_cnt), 32'd0);

      // Enter T_HH from 22:58, then a too-short inc glitch
      cur_hh = 5'd22;
      cur_mm = 6'd58;
      press(1'b1, 1'b0, 1'b0, 7);
      chk("t_hh_field", 32'(edit_field), 32'd1);
      chk("t_hh_alarm", 32'(edit_alarm), 32'd0);
      @(negedge clk);
      btn_inc = 1'b1;
      cyc(3);
      btn_inc = 1'b0;
      cyc(14);
      chk("glitch_field", 32'(edit_field), 32'd1);

      // inc x2 wraps 22->23->0, dec on MM 58->57, commit
      press(1'b0, 1'b1, 1'b0, 7);
      press(1'b0, 1'b1, 1'b0, 7);
      press(1'b1, 1'b0, 1'b0, 7);
      chk("t_mm_field", 32'(edit_field), 32'd2);
      press(1'b0, 1'b0, 1'b1, 7);
      chk("t_mm_set_hidden", 32'(set_mm), 32'd0);
      tl_ref = tl_cnt;
      press(1'b1, 1'b0, 1'b0, 7);
      chk("commit1_strobe", 32'(tl_cnt - tl_ref), 32'd1);
      chk("commit1_set_hh", 32'(set_hh), 32'd0);
      chk("commit1_set_mm", 32'(set_mm), 32'd57);
      chk("a_hh_alarm", 32'(edit_alarm), 32'd1);
      chk("a_hh_field", 32'(edit_field), 32'd1);

      // Idle in A_HH until timeout
      cyc(40);
      chk("pre_timeout_field", 32'(edit_field), 32'd1);
      cyc(20);
      chk("timeout_field", 32'(edit_field), 32'd0);
      chk("timeout_alarm", 32'(edit_alarm), 32'd0);
      chk("timeout_no_aload", 32'(al_cnt), 32'd0);
      chk("timeout_alarm_hh", 32'(alarm_hh), 32'd0);
      chk("timeout_alarm_mm", 32'(alarm_mm), 32'd0);
      chk("timeout_set_kept", 32'(set_mm), 32'd57);

      // inc in IDLE ignored; mode+inc together only enters T_HH
      cur_hh = 5'd5;
      cur_mm = 6'd10;
      press(1'b0, 1'b1, 1'b0, 7);
      chk("idle_inc_field", 32'(edit_field), 32'd0);
      press(1'b1, 1'b1, 1'b0, 7);
      chk("mode_inc_field", 32'(edit_field), 32'd1);
      press(1'b1, 1'b0, 1'b0, 7);

      // Hold inc 30 cycles in T_MM: 1 press + 3 repeats, 10 -> 14
      @(negedge clk);
      btn_inc = 1'b1;
      cyc(30);
      btn_inc = 1'b0;
      cyc(14);
      tl_ref = tl_cnt;
      press(1'b1, 1'b0, 1'b0, 7);
      chk("commit2_strobe", 32'(tl_cnt - tl_ref), 32'd1);
      chk("commit2_set_hh", 32'(set_hh), 32'd5);
      chk("commit2_set_mm", 32'(set_mm), 32'd14);

      // Alarm edit: HH 0->23, inc+dec cancel, MM 0->59, commit
      press(1'b0, 1'b0, 1'b1, 7);
      press(1'b1, 1'b0, 1'b0, 7);
      chk("a_mm_field", 32'(edit_field), 32'd2);
      chk("a_mm_alarm", 32'(edit_alarm), 32'd1);
      press(1'b0, 1'b1, 1'b1, 7);
      press(1'b0, 1'b0, 1'b1, 7);
      chk("a_mm_alarm_hidden", 32'(alarm_mm), 32'd0);
      al_ref = al_cnt;
      press(1'b1, 1'b0, 1'b0, 7);
      chk("acommit_strobe", 32'(al_cnt - al_ref), 32'd1);
      chk("acommit_alarm_hh", 32'(alarm_hh), 32'd23);
      chk("acommit_alarm_mm", 32'(alarm_mm), 32'd59);
      chk("acommit_field", 32'(edit_field), 32'd0);
      chk("acommit_set_held", 32'(set_hh), 32'd5);

      // Reset in the middle of an A_MM edit
      cur_hh = 5'd7;
      cur_mm = 6'd30;
      press(1'b1, 1'b0, 1'b0, 7);
      press(1'b1, 1'b0, 1'b0, 7);
      press(1'b1, 1'b0, 1'b0, 7);
      chk("reload_set_hh", 32'(set_hh), 32'd7);
      press(1'b1, 1'b0, 1'b0, 7);
      chk("pre_rst_field", 32'(edit_field), 32'd2);
      press(1'b0, 1'b1, 1'b0, 7);
      al_ref = al_cnt;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_field", 32'(edit_field), 32'd0);
      chk("async_rst_alarm", 32'(edit_alarm), 32'd0);
      chk("async_rst_set_hh", 32'(set_hh), 32'd0);
      chk("async_rst_alarm_hh", 32'(alarm_hh), 32'd0);
      chk("async_rst_alarm_mm", 32'(alarm_mm), 32'd0);
      cyc(3);
      rst_n = 1'b1;
      cyc(20);
      chk("post_rst_field", 32'(edit_field), 32'd0);
      chk("post_rst_no_aload", 32'(al_cnt - al_ref), 32'd0);
      chk("post_rst_alarm_mm", 32'(alarm_mm), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
